restoring_divider: RTL and testbench

//  Sequential unsigned restoring divider, the inverse datapath of the shift-add multiplier.
//  It takes a divisor and a dividend from the same 8-bit switch bus and produces the

---
 rtl/restoring_divider.sv | 98 +++++++++
 tb/tb_restoring_divider.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one shift-subtract step per clock,
// divisor loaded from the shared switch bus, dividend applied with Run.
module restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ClearA_LoadB,
  input  logic             Run,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [1:0]       States
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  q, r, d;
  logic [CW-1:0]     cnt;
  logic              dbz;
  logic [WIDTH:0]    trial;

  // Shift the next dividend bit into R and try subtracting D; the borrow bit
  // decides between keeping the difference and restoring the shifted R.
  assign trial = {r, q[WIDTH-1]} - {1'b0, d};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      q     <= '0;
      r     <= '0;
      d     <= '0;
      cnt   <= '0;
      dbz   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ClearA_LoadB) begin
            d   <= Din;
            q   <= '0;
            r   <= '0;
            dbz <= 1'b0;
          end else if (Run) begin
            if (d != '0) begin
              q     <= Din;
              r     <= '0;
              cnt   <= '0;
              dbz   <= 1'b0;
              state <= CALC;
            end else begin
              q     <= '1;
              r     <= Din;
              dbz   <= 1'b1;
              state <= DONE;
            end
          end
        end
        CALC: begin
          if (!trial[WIDTH]) begin
            r <= trial[WIDTH-1:0];
            q <= {q[WIDTH-2:0], 1'b1};
          end else begin
            r <= {r[WIDTH-2:0], q[WIDTH-1]};
            q <= {q[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= DONE;
        end
        DONE: begin
          // Holding Run keeps us here so a held button never restarts.
          if (!Run) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Quotient  = q;
  assign Remainder = r;
  assign Divisor   = d;
  assign Busy      = (state == CALC);
  assign Done      = (state == DONE);
  assign DivByZero = dbz;
  assign States    = state;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed and random-vector bench for restoring_divider; expected values are
// hand-computed constants or plain integer division in the bench.
module tb_restoring_divider;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       ClearA_LoadB = 1'b0;
  logic       Run = 1'b0;
  logic [7:0] Din = '0;
  logic [7:0] Quotient, Remainder, Divisor;
  logic       Busy, Done, DivByZero;
  logic [1:0] States;

  int n_chk = 0;
  int n_err = 0;

  restoring_divider #(.WIDTH(8)) dut (
    .Clk(Clk), .Reset(Reset), .ClearA_LoadB(ClearA_LoadB), .Run(Run), .Din(Din),
    .Quotient(Quotient), .Remainder(Remainder), .Divisor(Divisor),
    .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .States(States)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic load(input logic [7:0] v);
    @(negedge Clk);
    ClearA_LoadB = 1'b1;
    Din = v;
    @(negedge Clk);
    ClearA_LoadB = 1'b0;
    chk("load_d", Divisor, v);
  endtask

  // Start a division and wait for Done; leaves Run high.
  task automatic start_div(input logic [7:0] a, output int cycles, output int busy_n);
    @(negedge Clk);
    Run = 1'b1;
    Din = a;
    @(negedge Clk);
    cycles = 1;
    busy_n = 0;
    while (!Done && cycles < 40) begin
      if (Busy) busy_n++;
      Din = ~Din;  // CALC must ignore bus changes
      @(negedge Clk);
      cycles++;
    end
  endtask

  task automatic release_run();
    Run = 1'b0;
    @(negedge Clk);
    chk("idle_after_done", States, 0);
  endtask

  task automatic div_case(input string tag, input logic [7:0] b, input logic [7:0] a,
                          input logic [7:0] eq, input logic [7:0] er, input logic edz);
    int cyc, bz;
    load(b);
    start_div(a, cyc, bz);
    chk({tag, "_cycles"}, cyc, edz ? 1 : 9);
    chk({tag, "_busy"}, bz, edz ? 0 : 8);
    chk({tag, "_q"}, Quotient, eq);
    chk({tag, "_r"}, Remainder, er);
    chk({tag, "_dbz"}, DivByZero, edz);
    chk({tag, "_d"}, Divisor, b);
    release_run();
  endtask

  initial begin
    int cyc, bz, bad;
    logic [7:0] hq, hr;

    #12;
    chk("rst_q", Quotient, 0);
    chk("rst_r", Remainder, 0);
    chk("rst_d", Divisor, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_dbz", DivByZero, 0);
    chk("rst_state", States, 0);
    Reset = 1'b0;

    div_case("d100_7",   8'd7,   8'd100, 8'd14,  8'd2,  1'b0);
    div_case("d255_1",   8'd1,   8'd255, 8'd255, 8'd0,  1'b0);
    div_case("d255_255", 8'd255, 8'd255, 8'd1,   8'd0,  1'b0);
    div_case("d5_9",     8'd9,   8'd5,   8'd0,   8'd5,  1'b0);
    div_case("d0_200",   8'd200, 8'd0,   8'd0,   8'd0,  1'b0);
    div_case("d42_0",    8'd0,   8'd42,  8'hFF,  8'd42, 1'b1);

    // Async reset in the middle of a 100/7 division.
    load(8'd7);
    @(negedge Clk);
    Run = 1'b1;
    Din = 8'd100;
    repeat (4) @(negedge Clk);
    chk("mid_busy", Busy, 1);
    #2 Reset = 1'b1;
    #1;
    chk("arst_q", Quotient, 0);
    chk("arst_r", Remainder, 0);
    chk("arst_d", Divisor, 0);
    chk("arst_busy", Busy, 0);
    chk("arst_state", States, 0);
    Reset = 1'b0;
    Run = 1'b0;

    // Held Run after Done must not restart.
    load(8'd7);
    start_div(8'd100, cyc, bz);
    chk("hold_cycles", cyc, 9);
    bad = 0;
    repeat (20) begin
      @(negedge Clk);
      if (Busy || !Done || Quotient != 8'd14 || Remainder != 8'd2) bad++;
    end
    chk("hold_stable", bad, 0);
    release_run();
    chk("idle_keep_q", Quotient, 14);
    chk("idle_keep_r", Remainder, 2);
    @(negedge Clk);
    Run = 1'b1;
    ClearA_LoadB = 1'b1;
    Din = 8'd33;
    @(negedge Clk);
    chk("both_d", Divisor, 33);
    chk("both_state", States, 0);
    chk("both_q", Quotient, 0);
    Run = 1'b0;
    ClearA_LoadB = 1'b0;

    // Random-order sweep against integer division.
    for (int i = 0; i < 250; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom_range(0, 255));
      b = (i % 25 == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      hq = (b == 0) ? 8'hFF : a / b;
      hr = (b == 0) ? a : a % b;
      load(b);
      start_div(a, cyc, bz);
      chk("rnd_cycles", cyc, (b == 0) ? 1 : 9);
      chk("rnd_q", Quotient, hq);
      chk("rnd_r", Remainder, hr);
      if (b != 0)
        chk("rnd_inv", 32'(Quotient) * 32'(b) + 32'(Remainder), 32'(a));
      Run = 1'b0;
      @(negedge Clk);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
